// File: rtl/nram_stream_reader_pkg.sv
// Shared defaults and FSM state type for the NRAM neuron stream reader.
package nram_stream_pkg;
  localparam int DATA_W_DEF     = 512;
  localparam int ADDR_W_DEF     = 10;
  localparam int LEN_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;
endpackage

// File: rtl/nram_stream_reader_fifo.sv
// stream_fifo: small synchronous FIFO with registered storage; head is the oldest entry.
module stream_fifo
  import nram_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/nram_stream_reader.sv
// NRAM-to-matrix-PE neuron stream reader: credit-limited reads into a small FIFO.
// Optional stall counter port enabled by defining NRAM_STREAM_READER_PERF_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing reads and draining the FIFO to the PE
// DONE  | one-cycle done pulse, then back to IDLE
module nram_stream_reader
  import nram_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef NRAM_STREAM_READER_PERF_EN
  , output logic [31:0]     perf_stall_cnt
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d, popped_q, popped_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, pop, last_word;

  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign last_word  = (popped_q == len_q - LEN_W'(1));
  assign out_last   = out_valid && last_word;
  assign sram_raddr = base_q + ADDR_W'(issued_q);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    sram_ren   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          base_d   = cmd_addr;
          len_d    = cmd_len;
          issued_d = '0;
          popped_d = '0;
          state_d  = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Credit counts the word still on the SRAM bus; a pop this cycle frees nothing yet.
        sram_ren = (issued_q < len_q) &&
                   ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
        if (sram_ren) issued_d = issued_q + LEN_W'(1);
        if (pop) begin
          popped_d = popped_q + LEN_W'(1);
          if (last_word) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    inflight_d = sram_ren;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
    end
  end

  stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (sram_rdata),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef NRAM_STREAM_READER_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE) begin
      if (cmd_valid) perf_d = '0;
    end else if (out_valid && !out_ready && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif
endmodule

// File: tb/tb_nram_stream_reader.sv
// Directed bench for nram_stream_reader: command table plus reset/backpressure sequences.
module tb_nram_stream_reader;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              sram_ren;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef NRAM_STREAM_READER_PERF_EN
  logic [31:0]       perf_stall_cnt;
`endif

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  nram_stream_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .sram_ren   (sram_ren),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef NRAM_STREAM_READER_PERF_EN
    , .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] nram_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = {a, 6'(i), 16'hC0DE};
    return w;
  endfunction

  // NRAM model: one-cycle read latency
  always @(posedge clk) if (sram_ren) sram_rdata <= nram_word(sram_raddr);

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    int                stall;
    bit                hold;
    int                exp_done_k;
    int                exp_first_k;
    int                exp_max_buf;
    logic [ADDR_W-1:0] exp_last_raddr;
  } vec_t;

  vec_t vecs[6];

  int r_xfer, r_done_k, r_first_k, r_max_buf, r_ren, r_done_cnt, r_bad;
  logic [ADDR_W-1:0] r_last_raddr;

  // Called between a negedge and the next posedge; returns on the negedge after done.
  task automatic do_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input int stall,
                        input bit hold, input logic [ADDR_W-1:0] na, input logic [LEN_W-1:0] nl);
    bit fin;
    bit rdy;
    r_xfer = 0; r_done_k = -1; r_first_k = -1; r_max_buf = 0;
    r_ren = 0; r_done_cnt = 0; r_bad = 0; r_last_raddr = '0;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1; out_ready = 1'b1;
    if (cmd_ready !== 1'b1) r_bad++;
    @(posedge clk); #1;
    if (hold) begin cmd_addr = na; cmd_len = nl; end
    else cmd_valid = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 700 && !fin; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cmd_ready !== 1'b0) r_bad++;
      if (sram_ren === 1'b1) begin
        if (sram_raddr !== ADDR_W'(a + r_ren)) r_bad++;
        r_last_raddr = sram_raddr;
        r_ren++;
      end
      if (r_ren - r_xfer > r_max_buf) r_max_buf = r_ren - r_xfer;
      if (out_valid === 1'b1 && r_first_k < 0) r_first_k = k;
      rdy = !(r_first_k >= 0 && k < r_first_k + stall);
      out_ready = rdy;
      if (out_valid !== 1'b1 && out_last === 1'b1) r_bad++;
      if (out_valid === 1'b1 && rdy) begin
        if (out_data !== nram_word(ADDR_W'(a + r_xfer))) r_bad++;
        if (out_last !== (r_xfer == int'(l) - 1)) r_bad++;
        r_xfer++;
      end
      if (done === 1'b1) begin
        r_done_cnt++;
        r_done_k = k;
        fin = 1'b1;
      end
    end
    chk("cmd_completes", fin, 1);
    @(negedge clk);
    out_ready = 1'b1;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) r_bad++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfer, bad;
    vecs[0] = '{addr: 10'h010, len: 8'd4,   stall: 0,  hold: 0, exp_done_k: 6,   exp_first_k: 2,  exp_max_buf: 3, exp_last_raddr: 10'h013};
    vecs[1] = '{addr: 10'h3FE, len: 8'd4,   stall: 0,  hold: 1, exp_done_k: 6,   exp_first_k: 2,  exp_max_buf: 3, exp_last_raddr: 10'h001};
    vecs[2] = '{addr: 10'h100, len: 8'd8,   stall: 10, hold: 0, exp_done_k: 20,  exp_first_k: 2,  exp_max_buf: 4, exp_last_raddr: 10'h107};
    vecs[3] = '{addr: 10'h055, len: 8'd0,   stall: 0,  hold: 0, exp_done_k: 0,   exp_first_k: -1, exp_max_buf: 0, exp_last_raddr: 10'h000};
    vecs[4] = '{addr: 10'h3FF, len: 8'd1,   stall: 0,  hold: 0, exp_done_k: 3,   exp_first_k: 2,  exp_max_buf: 1, exp_last_raddr: 10'h3FF};
    vecs[5] = '{addr: 10'h200, len: 8'd255, stall: 0,  hold: 0, exp_done_k: 257, exp_first_k: 2,  exp_max_buf: 3, exp_last_raddr: 10'h2FE};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sram_ren", sram_ren, 0);
    chk("rst_sram_raddr", sram_raddr, 0);
`ifdef NRAM_STREAM_READER_PERF_EN
    chk("rst_perf", perf_stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      int j;
      j = (i + 1 < 6) ? i + 1 : i;
      do_cmd(vecs[i].addr, vecs[i].len, vecs[i].stall, vecs[i].hold, vecs[j].addr, vecs[j].len);
      chk($sformatf("v%0d_transfers", i), r_xfer, vecs[i].len);
      chk($sformatf("v%0d_reads", i), r_ren, vecs[i].len);
      chk($sformatf("v%0d_done_cycle", i), r_done_k, vecs[i].exp_done_k);
      chk($sformatf("v%0d_done_pulses", i), r_done_cnt, 1);
      chk($sformatf("v%0d_first_valid", i), r_first_k, vecs[i].exp_first_k);
      chk($sformatf("v%0d_max_buffered", i), r_max_buf, vecs[i].exp_max_buf);
      chk($sformatf("v%0d_protocol_errs", i), r_bad, 0);
      if (vecs[i].len != 0)
        chk($sformatf("v%0d_last_raddr", i), r_last_raddr, vecs[i].exp_last_raddr);
`ifdef NRAM_STREAM_READER_PERF_EN
      chk($sformatf("v%0d_perf", i), perf_stall_cnt, vecs[i].stall);
`endif
    end

    // Reset in the middle of a stream after a 5-cycle stall and 3 transfers.
    cmd_addr = 10'h300; cmd_len = 8'd8; cmd_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    xfer = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = (k < 2 || k > 6);
      if (out_valid === 1'b1 && out_ready) xfer++;
    end
    @(negedge clk);
    chk("mid_transfers", xfer, 3);
    chk("mid_busy", busy, 1);
`ifdef NRAM_STREAM_READER_PERF_EN
    chk("mid_perf", perf_stall_cnt, 5);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_done", done, 0);
    chk("mr_sram_ren", sram_ren, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    do_cmd(10'h010, 8'd2, 0, 1'b0, 10'h000, 8'd0);
    chk("rec_transfers", r_xfer, 2);
    chk("rec_done_cycle", r_done_k, 4);
    chk("rec_protocol_errs", r_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
